// File: rtl/wb_stage.sv
// wb_stage - write-back stage feeding the register file's single write port.
//
// Retiring instructions arrive over a valid/ready handshake. For instructions
// that write a register, the load or ALU result is selected and pushed into a
// 2-entry FIFO of {dest, data}. The FIFO drains one write per cycle into the
// register file unless the write port is held off. Pending destinations are
// exposed to the hazard unit through two combinational compare ports.
//
// Optional feature macro: WB_RETIRE_CNT_EN
//   defined   - retire_count counts every accepted instruction (wraps at 2^32)
//   undefined - no counter is built; retire_count is tied to 0
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   mem_valid/mem_ready  input handshake from the MEM stage
//   mem_wb_en, mem_r_en  instruction writes a register / is a load
//   alu_result, mem_data candidate write data
//   mem_dest             destination register
//   wb_hold              register-file write port unavailable this cycle
//   Dest_wb, Result_WB   head entry, presented to the register file
//   writeBackEn          register-file write strobe
//   hz_src1/2, hz_hit1/2 hazard lookup against buffered destinations
//   wb_count             occupied entries (0..2)
//   retire_count         accepted-instruction counter

module wb_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic                  mem_wb_en,
    input  logic                  mem_r_en,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [ADDR_WIDTH-1:0] mem_dest,
    input  logic                  wb_hold,
    output logic [ADDR_WIDTH-1:0] Dest_wb,
    output logic [DATA_WIDTH-1:0] Result_WB,
    output logic                  writeBackEn,
    input  logic [ADDR_WIDTH-1:0] hz_src1,
    input  logic [ADDR_WIDTH-1:0] hz_src2,
    output logic                  hz_hit1,
    output logic                  hz_hit2,
    output logic [1:0]            wb_count,
    output logic [31:0]           retire_count
);

    logic [ADDR_WIDTH-1:0] dest_q [2];
    logic [ADDR_WIDTH-1:0] dest_d [2];
    logic [DATA_WIDTH-1:0] data_q [2];
    logic [DATA_WIDTH-1:0] data_d [2];
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [1:0]            count_q, count_d;

    logic                  push;
    logic                  pop;
    logic [1:0]            occupied;

    // Ready and the write strobe depend only on registered count (plus the
    // hold input for the strobe), so no path from mem_valid reaches them.
    assign mem_ready   = (count_q != 2'd2);
    assign writeBackEn = (count_q != 2'd0) && !wb_hold;
    assign Dest_wb     = dest_q[head_q];
    assign Result_WB   = data_q[head_q];
    assign wb_count    = count_q;

    assign push = mem_valid && mem_ready && mem_wb_en;
    assign pop  = writeBackEn;

    always_comb begin
        dest_d  = dest_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            dest_d[tail_q] = mem_dest;
            data_d[tail_q] = mem_r_en ? mem_data : alu_result;
            tail_d         = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // With one entry only the head slot is live; with two both slots are.
    always_comb begin
        occupied[0] = (count_q == 2'd2) || ((count_q == 2'd1) && !head_q);
        occupied[1] = (count_q == 2'd2) || ((count_q == 2'd1) && head_q);
        hz_hit1     = 1'b0;
        hz_hit2     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (occupied[i] && (dest_q[i] == hz_src1)) hz_hit1 = 1'b1;
            if (occupied[i] && (dest_q[i] == hz_src2)) hz_hit2 = 1'b1;
        end
    end

    // Entries are cleared on reset so Dest_wb/Result_WB read 0 afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dest_q[0] <= '0;
            dest_q[1] <= '0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            dest_q  <= dest_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_q, retire_d;

    // Counts every accept, including instructions that write no register.
    always_comb begin
        retire_d = retire_q;
        if (mem_valid && mem_ready) retire_d = retire_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) retire_q <= 32'd0;
        else      retire_q <= retire_d;
    end

    assign retire_count = retire_q;
`else
    assign retire_count = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          mem_valid;
    logic          mem_ready;
    logic          mem_wb_en;
    logic          mem_r_en;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] mem_dest;
    logic          wb_hold;
    logic [AW-1:0] Dest_wb;
    logic [DW-1:0] Result_WB;
    logic          writeBackEn;
    logic [AW-1:0] hz_src1;
    logic [AW-1:0] hz_src2;
    logic          hz_hit1;
    logic          hz_hit2;
    logic [1:0]    wb_count;
    logic [31:0]   retire_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending writes in acceptance order, plus accept count.
    logic [AW-1:0] q_dest [$];
    logic [DW-1:0] q_data [$];
    logic [31:0]   m_retire;

    wb_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en),
        .alu_result(alu_result), .mem_data(mem_data), .mem_dest(mem_dest),
        .wb_hold(wb_hold),
        .Dest_wb(Dest_wb), .Result_WB(Result_WB), .writeBackEn(writeBackEn),
        .hz_src1(hz_src1), .hz_src2(hz_src2),
        .hz_hit1(hz_hit1), .hz_hit2(hz_hit2),
        .wb_count(wb_count), .retire_count(retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_retire();
`ifdef WB_RETIRE_CNT_EN
        return m_retire;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic model_hit(input logic [AW-1:0] src);
        foreach (q_dest[i]) if (q_dest[i] == src) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input logic v, input logic wb, input logic rd,
                         input logic [DW-1:0] alu, input logic [DW-1:0] md,
                         input logic [AW-1:0] dst, input logic hold);
        mem_valid  = v;
        mem_wb_en  = wb;
        mem_r_en   = rd;
        alu_result = alu;
        mem_data   = md;
        mem_dest   = dst;
        wb_hold    = hold;
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        logic do_pop, do_push, do_acc;
        logic [AW-1:0] d;
        logic [DW-1:0] v;
        do_acc  = mem_valid && (q_dest.size() != 2);
        do_push = do_acc && mem_wb_en;
        do_pop  = (q_dest.size() != 0) && !wb_hold;
        d = mem_dest;
        v = mem_r_en ? mem_data : alu_result;
        @(posedge clk);
        if (do_pop) begin
            void'(q_dest.pop_front());
            void'(q_data.pop_front());
        end
        if (do_push) begin
            q_dest.push_back(d);
            q_data.push_back(v);
        end
        if (do_acc) m_retire = m_retire + 32'd1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        hz_src1 = '0;
        hz_src2 = '0;
        q_dest.delete();
        q_data.delete();
        m_retire = 32'd0;
        #3;
        checks++; if (writeBackEn !== 1'b0) begin failures++; $display("FAIL reset_wben got=%b exp=0", writeBackEn); end
        checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", mem_ready); end
        checks++; if (Dest_wb !== '0 || Result_WB !== '0) begin failures++; $display("FAIL reset_head got=%h/%h exp=0/0", Dest_wb, Result_WB); end
        checks++; if (hz_hit1 !== 1'b0 || hz_hit2 !== 1'b0) begin failures++; $display("FAIL reset_hz got=%b%b exp=00", hz_hit1, hz_hit2); end
        checks++; if (wb_count !== 2'd0 || retire_count !== 32'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", wb_count, retire_count); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alu_push();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_000B, 32'hDEAD_BEEF, 4'd1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        checks++; if (writeBackEn !== 1'b1) begin failures++; $display("FAIL alu_wben got=%b exp=1", writeBackEn); end
        checks++; if (Dest_wb !== 4'd1 || Result_WB !== 32'h0000_000B) begin failures++; $display("FAIL alu_write got=%h/%h exp=1/0000000b", Dest_wb, Result_WB); end
        tick();
        checks++; if (wb_count !== 2'd0 || writeBackEn !== 1'b0) begin failures++; $display("FAIL alu_drained got=%0d/%b exp=0/0", wb_count, writeBackEn); end
    endtask

    task automatic test_load();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_000A, 32'h0000_0005, 4'd2, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        checks++; if (writeBackEn !== 1'b1 || Dest_wb !== 4'd2 || Result_WB !== 32'h5) begin failures++; $display("FAIL load_sel got=%b/%h/%h exp=1/2/00000005", writeBackEn, Dest_wb, Result_WB); end
        tick();
    endtask

    task automatic test_hold_fill();
        drive(1'b1, 1'b1, 1'b0, 32'h33, '0, 4'd3, 1'b1);
        tick();
        checks++; if (mem_ready !== 1'b1 || wb_count !== 2'd1) begin failures++; $display("FAIL hold_one got=%b/%0d exp=1/1", mem_ready, wb_count); end
        drive(1'b1, 1'b1, 1'b0, 32'h44, '0, 4'd4, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        hz_src1 = 4'd4;
        hz_src2 = 4'd7;
        #1;
        checks++; if (wb_count !== 2'd2 || mem_ready !== 1'b0) begin failures++; $display("FAIL hold_full got=%0d/%b exp=2/0", wb_count, mem_ready); end
        checks++; if (hz_hit1 !== 1'b1 || hz_hit2 !== 1'b0) begin failures++; $display("FAIL hold_hz got=%b%b exp=10", hz_hit1, hz_hit2); end
        checks++; if (writeBackEn !== 1'b0) begin failures++; $display("FAIL hold_wben got=%b exp=0", writeBackEn); end
        wb_hold = 1'b0;
        #1;
        checks++; if (writeBackEn !== 1'b1 || Dest_wb !== 4'd3 || Result_WB !== 32'h33) begin failures++; $display("FAIL release_first got=%b/%h/%h exp=1/3/33", writeBackEn, Dest_wb, Result_WB); end
        tick();
        checks++; if (mem_ready !== 1'b1 || Dest_wb !== 4'd4 || Result_WB !== 32'h44 || writeBackEn !== 1'b1) begin failures++; $display("FAIL release_second got=%b/%h/%h exp=1/4/44", mem_ready, Dest_wb, Result_WB); end
        tick();
        checks++; if (wb_count !== 2'd0) begin failures++; $display("FAIL release_empty got=%0d exp=0", wb_count); end
    endtask

    task automatic test_no_wb();
        drive(1'b1, 1'b0, 1'b0, 32'h99, 32'h98, 4'd5, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        checks++; if (writeBackEn !== 1'b0 || wb_count !== 2'd0) begin failures++; $display("FAIL nowb_push got=%b/%0d exp=0/0", writeBackEn, wb_count); end
        checks++; if (retire_count !== exp_retire()) begin failures++; $display("FAIL nowb_retire got=%0d exp=%0d", retire_count, exp_retire()); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b0);
            #1;
            checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready cyc=%0d got=%b exp=1", i, mem_ready); end
            tick();
            checks++; if (wb_count !== 2'(q_dest.size()) || q_dest.size() > 1) begin failures++; $display("FAIL b2b_count cyc=%0d got=%0d exp=%0d", i, wb_count, q_dest.size()); end
            checks++; if (q_dest.size() == 0 || Dest_wb !== q_dest[0] || Result_WB !== q_data[0]) begin failures++; $display("FAIL b2b_order cyc=%0d got=%h/%h", i, Dest_wb, Result_WB); end
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), $urandom, $urandom,
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0));
            hz_src1 = 4'($urandom_range(0, 15));
            hz_src2 = (q_dest.size() != 0 && $urandom_range(0, 1) == 1) ? q_dest[q_dest.size()-1] : 4'($urandom_range(0, 15));
            #1;
            checks++; if (mem_ready !== (q_dest.size() != 2)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b", i, mem_ready); end
            checks++; if (writeBackEn !== ((q_dest.size() != 0) && !wb_hold)) begin failures++; $display("FAIL rnd_wben cyc=%0d got=%b", i, writeBackEn); end
            checks++; if (wb_count !== 2'(q_dest.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, wb_count, q_dest.size()); end
            if (q_dest.size() != 0) begin
                checks++; if (Dest_wb !== q_dest[0] || Result_WB !== q_data[0]) begin failures++; $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", i, Dest_wb, Result_WB, q_dest[0], q_data[0]); end
            end
            checks++; if (hz_hit1 !== model_hit(hz_src1) || hz_hit2 !== model_hit(hz_src2)) begin failures++; $display("FAIL rnd_hz cyc=%0d got=%b%b exp=%b%b", i, hz_hit1, hz_hit2, model_hit(hz_src1), model_hit(hz_src2)); end
            checks++; if (retire_count !== exp_retire()) begin failures++; $display("FAIL rnd_retire cyc=%0d got=%0d exp=%0d", i, retire_count, exp_retire()); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h11, '0, 4'd6, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h22, '0, 4'd8, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        hz_src1 = 4'd6;
        hz_src2 = 4'd8;
        #1;
        checks++; if (wb_count !== 2'd2 || writeBackEn !== 1'b1) begin failures++; $display("FAIL arst_pre got=%0d/%b exp=2/1", wb_count, writeBackEn); end
        rst = 1'b0;
        #1;
        checks++; if (writeBackEn !== 1'b0 || wb_count !== 2'd0 || mem_ready !== 1'b1) begin failures++; $display("FAIL arst_now got=%b/%0d/%b exp=0/0/1", writeBackEn, wb_count, mem_ready); end
        checks++; if (Dest_wb !== '0 || Result_WB !== '0 || hz_hit1 !== 1'b0 || hz_hit2 !== 1'b0 || retire_count !== 32'd0) begin failures++; $display("FAIL arst_outs got=%h/%h/%b%b/%0d exp=0/0/00/0", Dest_wb, Result_WB, hz_hit1, hz_hit2, retire_count); end
        q_dest.delete();
        q_data.delete();
        m_retire = 32'd0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h77, '0, 4'd9, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        checks++; if (writeBackEn !== 1'b1 || Dest_wb !== 4'd9 || Result_WB !== 32'h77 || retire_count !== exp_retire()) begin failures++; $display("FAIL arst_after got=%b/%h/%h/%0d", writeBackEn, Dest_wb, Result_WB, retire_count); end
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_push();
        test_load();
        test_hold_fill();
        test_no_wb();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage between the MEM/WB pipeline boundary and the register file's single write port. Accepts retiring instructions over a valid/ready handshake and picks the load or ALU result. A 2-entry FIFO holds the chosen results, which drain into the register file one write per cycle. It also reports which register numbers still have writes pending, so the hazard unit can stall reads of those registers.

## Interface
- DATA_WIDTH, 32, width of Result_WB and data inputs
- ADDR_WIDTH, 4, width of register numbers (Dest_wb, mem_dest, hz_src*)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mem_valid  in  1  MEM stage presents an instruction
- mem_ready  out  1  stage can accept this cycle
- mem_wb_en  in  1  instruction writes a register
- mem_r_en  in  1  instruction is a load (selects mem_data)
- alu_result  in  DATA_WIDTH  ALU result
- mem_data  in  DATA_WIDTH  load data
- mem_dest  in  ADDR_WIDTH  destination register
- wb_hold  in  1  register-file write port unavailable this cycle
- Dest_wb  out  ADDR_WIDTH  write address to register file
- Result_WB  out  DATA_WIDTH  write data to register file
- writeBackEn  out  1  write strobe to register file
- hz_src1, hz_src2  in  ADDR_WIDTH  source registers being decoded
- hz_hit1, hz_hit2  out  1  matching write still pending in buffer
- wb_count  out  2  entries occupied (0..2)
- retire_count  out  32  accepted-instruction counter (see Configuration)

## Operation
- Storage: 2-entry FIFO of {dest, data}; head pointer, tail pointer, 2-bit count; pointers wrap 1→0.
- Accept: happens on a rising edge when mem_valid && mem_ready.
  - If mem_wb_en=1: push {mem_dest, mem_r_en ? mem_data : alu_result}.
  - If mem_wb_en=0: the instruction is accepted and discarded; no push.
- mem_ready = (wb_count != 2). Decoded from registers only; no combinational path from mem_valid or wb_hold.
- Drain: writeBackEn = (wb_count != 0) && !wb_hold. Dest_wb/Result_WB always show the head entry. The head is popped on an edge where writeBackEn=1.
- Simultaneous push and pop: count unchanged, both pointers advance. At count=2 no push occurs, because ready is low.
- Ordering: writes leave in acceptance order. Two entries may share a destination; the later one lands last.
- Register 0 is not treated specially; the register file decides.
- Hazard outputs are combinational: hz_hitN = OR over occupied entries of (entry.dest == hz_srcN). Entries still on the input this cycle are not included.
- Reset (rst=0, any time):
  - Count, pointers and retire_count go to 0.
  - Outputs: writeBackEn=0, mem_ready=1, Dest_wb=0, Result_WB=0, hz_hit*=0.
  - Buffered writes are lost.

## Timing
- Latency: instruction accepted at edge k → writeBackEn=1 during cycle k..k+1 (if wb_hold=0) → register file writes at edge k+1.
- Throughput: 1 write per cycle sustained with wb_hold=0; mem_ready stays 1.
- wb_hold high for n cycles:
  - Buffer fills after at most 2 accepts; mem_ready drops the cycle after the second push.
  - Ready returns the cycle after the first pop.
- rst is sampled asynchronously. Release is followed by normal operation at the first rising edge with rst=1.

## Configuration
- WB_RETIRE_CNT_EN defined:
  - retire_count increments by 1 on every accept, including mem_wb_en=0.
  - Wraps modulo 2^32; reset to 0.
- WB_RETIRE_CNT_EN undefined:
  - The counter is not built and retire_count is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, then push alu_result=0x0000000B, dest=1, mem_r_en=0 → next cycle writeBackEn=1, Dest_wb=1, Result_WB=0x0B; wb_count returns to 0 after that edge.
- Load: mem_r_en=1, mem_data=0x5, alu_result=0xA, dest=2 → Result_WB=0x5.
- wb_hold=1, push dest 3 then dest 4:
  - wb_count=2, mem_ready=0, hz_src1=4 gives hz_hit1=1.
  - Release hold → writes of 3 then 4 on consecutive edges; mem_ready=1 after the first.
- Push with mem_wb_en=0 → no writeBackEn, wb_count stays 0; retire_count +1 with WB_RETIRE_CNT_EN, stays 0 without.
- Back-to-back pushes every cycle with wb_hold=0 → count stays at most 1, mem_ready never drops, writes appear in order.
- Drop rst mid-cycle with 2 entries held → writeBackEn=0 and wb_count=0 immediately (before the next edge); mem_ready=1.
